// File: rtl/rvfi_mem_latency_model.sv
// rvfi_mem_latency_model
// Read-response timing model for one memory port (imem or dmem).
// LATENCY=0 is a combinational pass-through (SRAM timing). LATENCY>=1 is an
// L-stage {valid, addr, data} pipeline with bounded stall injection, and the
// last stage drives the response. Stall injection only happens while a read
// is in flight. While stalled, the whole pipeline freezes so the response
// stays bit-stable.
module rvfi_mem_latency_model #(
  parameter int              AW         = 32,
  parameter int              DW         = 32,
  parameter int              LATENCY    = 1,
  parameter int              MAX_STALL  = 2,
  parameter logic [DW-1:0]   INIT_RDATA = 32'h00000013
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] src_rdata,
  input  logic          stall_req,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] rsp_addr,
  output logic          stall,
  output logic          pending,
  output logic [2:0]    stall_cnt
);

  // Reject parameter values the model cannot represent.
  generate
    if (LATENCY < 0 || LATENCY > 4) begin : g_bad_latency
      $error("rvfi_mem_latency_model: LATENCY must be in 0..4");
    end
    if (MAX_STALL < 1 || MAX_STALL > 7) begin : g_bad_max_stall
      $error("rvfi_mem_latency_model: MAX_STALL must be in 1..7");
    end
  endgenerate

  generate
    if (LATENCY == 0) begin : g_passthru
      // SRAM timing: the response is the request, and there is never a stall.
      assign rsp_valid = req_valid;
      assign rsp_rdata = src_rdata;
      assign rsp_addr  = req_addr;
      assign stall     = 1'b0;
      assign pending   = 1'b0;
      assign stall_cnt = 3'd0;

      // Clock, reset and stall_req have no function without state.
      logic unused_s;
      assign unused_s = ^{clock, reset, stall_req};
    end else begin : g_pipe
      localparam logic [2:0] MAX_STALL_C = 3'(MAX_STALL);

      // Stage LATENCY-1 is the output stage.
      logic [LATENCY-1:0]         vld_q;
      logic [LATENCY-1:0]         vld_d;
      logic [LATENCY-1:0][AW-1:0] addr_q;
      logic [LATENCY-1:0][AW-1:0] addr_d;
      logic [LATENCY-1:0][DW-1:0] data_q;
      logic [LATENCY-1:0][DW-1:0] data_d;
      logic [2:0]                 stall_cnt_q;
      logic [2:0]                 stall_cnt_d;
      logic                       pending_s;
      logic                       stall_s;

      // Stall only when a read is in flight and the consecutive-stall budget remains.
      always_comb begin
        pending_s = |vld_q;
        stall_s   = stall_req & pending_s & (stall_cnt_q < MAX_STALL_C);
      end

      // Count consecutive stall cycles; any non-stalled cycle clears the count.
      always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_s) begin
          if (stall_cnt_q < MAX_STALL_C) begin
            stall_cnt_d = stall_cnt_q + 3'd1;
          end else begin
            stall_cnt_d = stall_cnt_q;
          end
        end else begin
          stall_cnt_d = 3'd0;
        end
      end

      // Advance the pipeline unless stalled. Payload moves only with a valid
      // bit, so an idle stage keeps its last data.
      always_comb begin
        vld_d  = vld_q;
        addr_d = addr_q;
        data_d = data_q;
        if (!stall_s) begin
          vld_d[0] = req_valid;
          if (req_valid) begin
            addr_d[0] = req_addr;
            data_d[0] = src_rdata;
          end else begin
            addr_d[0] = addr_q[0];
            data_d[0] = data_q[0];
          end
          for (int k = 1; k < LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
            if (vld_q[k-1]) begin
              addr_d[k] = addr_q[k-1];
              data_d[k] = data_q[k-1];
            end else begin
              addr_d[k] = addr_q[k];
              data_d[k] = data_q[k];
            end
          end
        end else begin
          vld_d  = vld_q;
          addr_d = addr_q;
          data_d = data_q;
        end
      end

      // Pipeline and stall-counter registers. Reset discards every in-flight read.
      always_ff @(posedge clock) begin
        if (reset) begin
          vld_q       <= '0;
          addr_q      <= '0;
          data_q      <= {LATENCY{INIT_RDATA}};
          stall_cnt_q <= 3'd0;
        end else begin
          vld_q       <= vld_d;
          addr_q      <= addr_d;
          data_q      <= data_d;
          stall_cnt_q <= stall_cnt_d;
        end
      end

      assign rsp_valid = vld_q[LATENCY-1];
      assign rsp_rdata = data_q[LATENCY-1];
      assign rsp_addr  = addr_q[LATENCY-1];
      assign stall     = stall_s;
      assign pending   = pending_s;
      assign stall_cnt = stall_cnt_q;
    end
  endgenerate

endmodule

// File: tb/tb_rvfi_mem_latency_model.sv
// Testbench for rvfi_mem_latency_model: four instances (LATENCY 0, 1, 3, 4)
// share one stimulus stream. A vector table drives stall-free traffic, and a
// scoreboard checks every response's address, data and arrival cycle.
// Hand-written sequences cover the stall bound, stall gating, reset
// mid-flight and the combinational mode.
module tb_rvfi_mem_latency_model;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [31:0] src_rdata;
  logic        stall_req;

  logic        rsp_valid_l0, rsp_valid_l1, rsp_valid_l3, rsp_valid_l4;
  logic [31:0] rsp_rdata_l0, rsp_rdata_l1, rsp_rdata_l3, rsp_rdata_l4;
  logic [31:0] rsp_addr_l0, rsp_addr_l1, rsp_addr_l3, rsp_addr_l4;
  logic        stall_l0, stall_l1, stall_l3, stall_l4;
  logic        pending_l0, pending_l1, pending_l3, pending_l4;
  logic [2:0]  stall_cnt_l0, stall_cnt_l1, stall_cnt_l3, stall_cnt_l4;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic sb_en = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
  } sb_item_t;

  sb_item_t q1[$];
  sb_item_t q3[$];
  sb_item_t q4[$];
  sb_item_t e1, e3, e4;

  typedef struct {
    logic        rv;
    logic [31:0] addr;
    logic [31:0] data;
    logic        pend1;
    logic        pend3;
  } vec_t;

  vec_t tv[10];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  rvfi_mem_latency_model #(.LATENCY(0)) u_l0 (
    .clock(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .src_rdata(src_rdata), .stall_req(stall_req), .rsp_valid(rsp_valid_l0),
    .rsp_rdata(rsp_rdata_l0), .rsp_addr(rsp_addr_l0), .stall(stall_l0),
    .pending(pending_l0), .stall_cnt(stall_cnt_l0));

  rvfi_mem_latency_model #(.LATENCY(1), .MAX_STALL(2)) u_l1 (
    .clock(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .src_rdata(src_rdata), .stall_req(stall_req), .rsp_valid(rsp_valid_l1),
    .rsp_rdata(rsp_rdata_l1), .rsp_addr(rsp_addr_l1), .stall(stall_l1),
    .pending(pending_l1), .stall_cnt(stall_cnt_l1));

  rvfi_mem_latency_model #(.LATENCY(3)) u_l3 (
    .clock(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .src_rdata(src_rdata), .stall_req(stall_req), .rsp_valid(rsp_valid_l3),
    .rsp_rdata(rsp_rdata_l3), .rsp_addr(rsp_addr_l3), .stall(stall_l3),
    .pending(pending_l3), .stall_cnt(stall_cnt_l3));

  rvfi_mem_latency_model #(.LATENCY(4)) u_l4 (
    .clock(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .src_rdata(src_rdata), .stall_req(stall_req), .rsp_valid(rsp_valid_l4),
    .rsp_rdata(rsp_rdata_l4), .rsp_addr(rsp_addr_l4), .stall(stall_l4),
    .pending(pending_l4), .stall_cnt(stall_cnt_l4));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic cmp_rsp(input string nm, input sb_item_t e, input logic [31:0] a,
                         input logic [31:0] d);
    chk({nm, "_addr"}, a, e.addr);
    chk({nm, "_data"}, d, e.data);
    chk({nm, "_latency"}, 32'(cyc), 32'(e.due));
  endtask

  task automatic chk_reset(input string nm, input logic v, input logic [31:0] d,
                           input logic [31:0] a, input logic st, input logic pd,
                           input logic [2:0] sc);
    chkb({nm, "_rst_valid"}, v, 1'b0);
    chk({nm, "_rst_rdata"}, d, 32'h00000013);
    chk({nm, "_rst_addr"}, a, 32'h0);
    chkb({nm, "_rst_stall"}, st, 1'b0);
    chkb({nm, "_rst_pending"}, pd, 1'b0);
    chk({nm, "_rst_cnt"}, {29'd0, sc}, 32'd0);
  endtask

  // Drive one cycle of stimulus; stall-free requests are expected back on every pipelined instance.
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic sr, input logic rst);
    req_valid = v;
    req_addr  = a;
    src_rdata = d;
    stall_req = sr;
    reset     = rst;
    if (sb_en && v && !sr && !rst) begin
      q1.push_back('{addr: a, data: d, due: cyc + 1});
      q3.push_back('{addr: a, data: d, due: cyc + 3});
      q4.push_back('{addr: a, data: d, due: cyc + 4});
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: each consumed response must match the oldest outstanding request.
  always @(negedge clk) begin
    if (sb_en && rsp_valid_l1 && !stall_l1) begin
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL L1_unexpected: actual rsp addr 0x%0h required no response", rsp_addr_l1);
      end else begin
        e1 = q1.pop_front();
        cmp_rsp("L1", e1, rsp_addr_l1, rsp_rdata_l1);
      end
    end
    if (sb_en && rsp_valid_l3 && !stall_l3) begin
      if (q3.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL L3_unexpected: actual rsp addr 0x%0h required no response", rsp_addr_l3);
      end else begin
        e3 = q3.pop_front();
        cmp_rsp("L3", e3, rsp_addr_l3, rsp_rdata_l3);
      end
    end
    if (sb_en && rsp_valid_l4 && !stall_l4) begin
      if (q4.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL L4_unexpected: actual rsp addr 0x%0h required no response", rsp_addr_l4);
      end else begin
        e4 = q4.pop_front();
        cmp_rsp("L4", e4, rsp_addr_l4, rsp_rdata_l4);
      end
    end
  end

  // Watchdog: the run is short; reaching this means something hung.
  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // rv, addr, data, expected L1 pending, expected L3 pending
    tv[0] = '{1'b1, 32'h00, 32'hA0,   1'b0, 1'b0};
    tv[1] = '{1'b1, 32'h04, 32'hA1,   1'b1, 1'b1};
    tv[2] = '{1'b1, 32'h08, 32'hA2,   1'b1, 1'b1};
    tv[3] = '{1'b0, 32'h0C, 32'hFF,   1'b1, 1'b1};
    tv[4] = '{1'b1, 32'h10, 32'h1234, 1'b0, 1'b1};
    tv[5] = '{1'b0, 32'h14, 32'h0,    1'b1, 1'b1};
    tv[6] = '{1'b0, 32'h18, 32'h0,    1'b0, 1'b1};
    tv[7] = '{1'b0, 32'h1C, 32'h0,    1'b0, 1'b1};
    tv[8] = '{1'b0, 32'h20, 32'h0,    1'b0, 1'b0};
    tv[9] = '{1'b1, 32'h24, 32'h77,   1'b0, 1'b0};

    // Reset state
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    repeat (2) next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk_reset("L1", rsp_valid_l1, rsp_rdata_l1, rsp_addr_l1, stall_l1, pending_l1, stall_cnt_l1);
    chk_reset("L3", rsp_valid_l3, rsp_rdata_l3, rsp_addr_l3, stall_l3, pending_l3, stall_cnt_l3);
    chk_reset("L4", rsp_valid_l4, rsp_rdata_l4, rsp_addr_l4, stall_l4, pending_l4, stall_cnt_l4);
    next_cycle();

    // Table-driven stall-free traffic; responses checked by the scoreboard
    sb_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(tv[i].rv, tv[i].addr, tv[i].data, 1'b0, 1'b0);
      @(negedge clk);
      chkb("L0_valid", rsp_valid_l0, tv[i].rv);
      chk("L0_rdata", rsp_rdata_l0, tv[i].data);
      chk("L0_addr", rsp_addr_l0, tv[i].addr);
      chkb("L1_pending", pending_l1, tv[i].pend1);
      chkb("L3_pending", pending_l3, tv[i].pend3);
      next_cycle();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (6) next_cycle();
    chk("sb_drain", 32'(q1.size() + q3.size() + q4.size()), 32'd0);
    sb_en = 1'b0;

    // Stall bound on L1 (MAX_STALL=2): stall for two cycles, then forced release
    drive(1'b1, 32'h40, 32'hB0, 1'b0, 1'b0);
    @(negedge clk); chkb("s0_stall", stall_l1, 1'b0);
    next_cycle();
    drive(1'b1, 32'h44, 32'hB1, 1'b1, 1'b0);
    @(negedge clk);
    chkb("s1_stall", stall_l1, 1'b1);
    chk("s1_cnt", {29'd0, stall_cnt_l1}, 32'd0);
    chkb("s1_valid", rsp_valid_l1, 1'b1);
    chk("s1_rdata", rsp_rdata_l1, 32'hB0);
    next_cycle();
    @(negedge clk);
    chkb("s2_stall", stall_l1, 1'b1);
    chk("s2_cnt", {29'd0, stall_cnt_l1}, 32'd1);
    chk("s2_rdata", rsp_rdata_l1, 32'hB0);
    chk("s2_addr", rsp_addr_l1, 32'h40);
    next_cycle();
    @(negedge clk);
    chkb("s3_stall", stall_l1, 1'b0);
    chk("s3_cnt", {29'd0, stall_cnt_l1}, 32'd2);
    chkb("s3_valid", rsp_valid_l1, 1'b1);
    chk("s3_rdata", rsp_rdata_l1, 32'hB0);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("s4_rdata", rsp_rdata_l1, 32'hB1);
    chk("s4_addr", rsp_addr_l1, 32'h44);
    chk("s4_cnt", {29'd0, stall_cnt_l1}, 32'd0);
    chkb("s4_stall", stall_l1, 1'b1);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chkb("s5_stall", stall_l1, 1'b0);
    chk("s5_cnt", {29'd0, stall_cnt_l1}, 32'd1);
    chkb("s5_valid", rsp_valid_l1, 1'b1);
    chk("s5_rdata", rsp_rdata_l1, 32'hB1);
    next_cycle();
    @(negedge clk);
    chkb("s6_valid", rsp_valid_l1, 1'b0);
    chkb("s6_pending", pending_l1, 1'b0);
    next_cycle();
    repeat (8) next_cycle();

    // Stall gating: stall requests with nothing in flight are ignored
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chkb("gate_stall_l1", stall_l1, 1'b0);
      chkb("gate_stall_l3", stall_l3, 1'b0);
      chkb("gate_stall_l4", stall_l4, 1'b0);
      chkb("gate_pend_l1", pending_l1, 1'b0);
      chkb("gate_pend_l4", pending_l4, 1'b0);
      next_cycle();
    end

    // Reset mid-flight on L4, with a request in the reset cycle itself
    drive(1'b1, 32'h50, 32'hC0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 32'h54, 32'hC1, 1'b0, 1'b0);
    @(negedge clk); chkb("r1_pend4", pending_l4, 1'b1);
    next_cycle();
    drive(1'b1, 32'h58, 32'hC2, 1'b0, 1'b1);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chkb("rmf_valid_l4", rsp_valid_l4, 1'b0);
      chk("rmf_rdata_l4", rsp_rdata_l4, 32'h00000013);
      chkb("rmf_pend_l4", pending_l4, 1'b0);
      next_cycle();
    end

    // Combinational mode ignores stall_req
    drive(1'b1, 32'h20, 32'hDEAD, 1'b1, 1'b0);
    @(negedge clk);
    chkb("l0_valid", rsp_valid_l0, 1'b1);
    chk("l0_rdata", rsp_rdata_l0, 32'hDEAD);
    chk("l0_addr", rsp_addr_l0, 32'h20);
    chkb("l0_stall", stall_l0, 1'b0);
    chkb("l0_pending", pending_l0, 1'b0);
    chk("l0_cnt", {29'd0, stall_cnt_l0}, 32'd0);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
